// File: rtl/num_entry_pkg.sv
// Shared constants for the keypad number-entry stage: key codes, operator
// codes, display message words and the entry FSM state type.
package num_entry_pkg;

    localparam int MAG_W_DEF   = 17;
    localparam int MAX_MAG_DEF = 99999;

    localparam logic [4:0] KEY_SIGN  = 5'd10;
    localparam logic [4:0] KEY_BSP   = 5'd11;
    localparam logic [4:0] KEY_CLR   = 5'd12;
    localparam logic [4:0] KEY_PLUS  = 5'd13;
    localparam logic [4:0] KEY_MINUS = 5'd14;
    localparam logic [4:0] KEY_MUL   = 5'd15;
    localparam logic [4:0] KEY_DIV   = 5'd16;
    localparam logic [4:0] KEY_MOD   = 5'd17;

    localparam logic [2:0] OP_NONE  = 3'd0;
    localparam logic [2:0] OP_PLUS  = 3'd1;
    localparam logic [2:0] OP_MINUS = 3'd2;
    localparam logic [2:0] OP_MUL   = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_MOD   = 3'd5;

    localparam logic [31:0] MSG_PLUS  = 32'h0010_0000;
    localparam logic [31:0] MSG_MINUS = 32'h0020_0000;
    localparam logic [31:0] MSG_MUL   = 32'h0030_0000;
    localparam logic [31:0] MSG_DIV   = 32'h0040_0000;
    localparam logic [31:0] MSG_MOD   = 32'h0050_0000;
    localparam logic [31:0] MSG_HAPPY = 32'h00A0_0000;
    localparam logic [31:0] MSG_ERR   = 32'h00EE_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_MSG  = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    function automatic logic [2:0] key_to_op(input logic [4:0] key);
        case (key)
            KEY_PLUS:  return OP_PLUS;
            KEY_MINUS: return OP_MINUS;
            KEY_MUL:   return OP_MUL;
            KEY_DIV:   return OP_DIV;
            KEY_MOD:   return OP_MOD;
            default:   return OP_NONE;
        endcase
    endfunction

    function automatic logic [31:0] op_msg(input logic [2:0] op);
        case (op)
            OP_PLUS:  return MSG_PLUS;
            OP_MINUS: return MSG_MINUS;
            OP_MUL:   return MSG_MUL;
            OP_DIV:   return MSG_DIV;
            OP_MOD:   return MSG_MOD;
            default:  return 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/num_entry_seq_div10.sv
// Sequential restoring divider by 10: the start edge performs the first of
// MAG_W iterations, o_done is high for the cycle in which o_quot is final.
module seq_div10 #(
    parameter int MAG_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [MAG_W-1:0] i_dividend,
    output logic             o_busy,
    output logic             o_done,
    output logic [MAG_W-1:0] o_quot
);
    localparam int CNT_W = $clog2(MAG_W + 1);

    logic [4:0]       r_rem;
    logic [MAG_W-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;

    function automatic logic [MAG_W+4:0] div_step(input logic [4:0] rem,
                                                  input logic [MAG_W-1:0] q);
        logic [4:0]       t;
        logic [MAG_W-1:0] qs;
        t  = {rem[3:0], q[MAG_W-1]};
        qs = q << 1;
        if (t >= 5'd10) begin
            t     = t - 5'd10;
            qs[0] = 1'b1;
        end else begin
            qs[0] = 1'b0;
        end
        return {t, qs};
    endfunction

    // Iteration engine; quotient bits shift into r_q as the dividend shifts out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= 5'd0;
            r_q    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else if (i_start) begin
            {r_rem, r_q} <= div_step(5'd0, i_dividend);
            r_cnt        <= CNT_W'(MAG_W - 1);
            r_busy       <= 1'b1;
            r_done       <= (MAG_W == 1) ? 1'b1 : 1'b0;
        end else if (r_busy) begin
            if (r_cnt != '0) begin
                {r_rem, r_q} <= div_step(r_rem, r_q);
                r_cnt        <= r_cnt - CNT_W'(1);
                r_done       <= (r_cnt == CNT_W'(1)) ? 1'b1 : 1'b0;
            end else begin
                r_busy <= 1'b0;
                r_done <= 1'b0;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_quot = r_q;

endmodule

// File: rtl/num_entry.sv
// Keypad number-entry stage feeding the seven-segment driver.
// Optional macro NUM_ENTRY_HAPPY_EN: clear on an empty idle entry shows HAPPY.
module num_entry
    import num_entry_pkg::*;
#(
    parameter int          MAG_W      = MAG_W_DEF,
    parameter int          MAX_MAG    = MAX_MAG_DEF,
    parameter logic [23:0] MSG_CYCLES = 24'd12_000_000,
    parameter logic [23:0] ERR_CYCLES = 24'd12_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_key_valid,
    input  logic [4:0]  i_key_code,
    output logic        o_key_ready,
    output logic [31:0] o_fnd_serial,
    output logic [31:0] o_operand,
    output logic        o_op_valid,
    output logic [2:0]  o_op_code
);
    logic [MAG_W-1:0] r_mag;
    logic             r_neg;
    state_t           r_state;
    logic [23:0]      r_timer;
    logic [31:0]      r_msg;
    logic             r_op_pend;
    logic [2:0]       r_op_code;
    logic             r_op_valid;
    logic             r_key_ready;
    logic [31:0]      r_fnd;
    logic [31:0]      r_operand;

    logic [MAG_W-1:0] w_mag_b, w_mag_nxt, w_div_quot;
    logic             w_neg_b, w_neg_nxt;
    state_t           w_state_b, w_state_nxt;
    logic [23:0]      w_timer_b, w_timer_nxt;
    logic [31:0]      w_msg_b, w_msg_nxt, w_fnd_nxt, w_val_nxt;
    logic [MAG_W+3:0] w_dec;
    logic             w_accept, w_pend_nxt, w_op_valid_nxt, w_div_start;
    logic             w_div_busy, w_div_done;
    logic [2:0]       w_op_code_nxt;

    function automatic logic [31:0] signed_val(input logic [MAG_W-1:0] m, input logic n);
        logic [31:0] e;
        e = 32'(m);
        return n ? (32'd0 - e) : e;
    endfunction

    assign w_accept = i_key_valid & r_key_ready;
    assign w_dec    = ({4'd0, w_mag_b} << 3) + ({4'd0, w_mag_b} << 1) + (MAG_W+4)'(i_key_code);

    // Background evolution without a key: pending operator clear, timers, divider result
    always_comb begin
        w_mag_b   = r_mag;
        w_neg_b   = r_neg;
        w_state_b = r_state;
        w_timer_b = r_timer;
        w_msg_b   = r_msg;
        if (r_op_pend) begin
            w_mag_b   = '0;
            w_neg_b   = 1'b0;
            w_state_b = ST_MSG;
            w_timer_b = MSG_CYCLES;
            w_msg_b   = op_msg(r_op_code);
        end else begin
            case (r_state)
                ST_MSG, ST_ERR: begin
                    if (r_timer <= 24'd1) begin
                        w_state_b = ST_IDLE;
                        w_timer_b = 24'd0;
                    end else begin
                        w_timer_b = r_timer - 24'd1;
                    end
                end
                ST_DIV: begin
                    if (w_div_done) begin
                        w_mag_b   = w_div_quot;
                        w_neg_b   = (w_div_quot == '0) ? 1'b0 : r_neg;
                        w_state_b = ST_IDLE;
                    end else begin
                        w_state_b = ST_DIV;
                    end
                end
                default: ;
            endcase
        end
    end

    // Key processing on top of the background state; a key in MSG/ERR aborts the message
    always_comb begin
        w_mag_nxt      = w_mag_b;
        w_neg_nxt      = w_neg_b;
        w_state_nxt    = w_state_b;
        w_timer_nxt    = w_timer_b;
        w_msg_nxt      = w_msg_b;
        w_op_valid_nxt = 1'b0;
        w_op_code_nxt  = r_op_code;
        w_pend_nxt     = 1'b0;
        w_div_start    = 1'b0;
        if (w_accept) begin
            if (i_key_code <= 5'd9) begin
                if (w_dec <= (MAG_W+4)'(MAX_MAG)) begin
                    w_mag_nxt   = w_dec[MAG_W-1:0];
                    w_state_nxt = ST_IDLE;
                    w_timer_nxt = 24'd0;
                end else begin
                    w_state_nxt = ST_ERR;
                    w_timer_nxt = ERR_CYCLES;
                end
            end else begin
                case (i_key_code)
                    KEY_SIGN: begin
                        w_neg_nxt   = (w_mag_b != '0) ? ~w_neg_b : w_neg_b;
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = 24'd0;
                    end
                    KEY_BSP: begin
                        w_state_nxt = ST_DIV;
                        w_timer_nxt = 24'd0;
                        w_div_start = ~w_div_busy;
                    end
                    KEY_CLR: begin
                        w_mag_nxt   = '0;
                        w_neg_nxt   = 1'b0;
                        w_state_nxt = ST_IDLE;
                        w_timer_nxt = 24'd0;
`ifdef NUM_ENTRY_HAPPY_EN
                        if ((r_mag == '0) && (r_state == ST_IDLE) && !r_op_pend) begin
                            w_state_nxt = ST_MSG;
                            w_msg_nxt   = MSG_HAPPY;
                            w_timer_nxt = MSG_CYCLES;
                        end else begin
                            w_msg_nxt = w_msg_b;
                        end
`endif
                    end
                    KEY_PLUS, KEY_MINUS, KEY_MUL, KEY_DIV, KEY_MOD: begin
                        w_op_valid_nxt = 1'b1;
                        w_op_code_nxt  = key_to_op(i_key_code);
                        w_pend_nxt     = 1'b1;
                        w_state_nxt    = ST_IDLE;
                        w_timer_nxt    = 24'd0;
                    end
                    default: ;
                endcase
            end
        end else begin
            w_div_start = 1'b0;
        end
    end

    assign w_val_nxt = signed_val(w_mag_nxt, w_neg_nxt);

    // Display word selection from the next state
    always_comb begin
        case (w_state_nxt)
            ST_MSG:  w_fnd_nxt = w_msg_nxt;
            ST_ERR:  w_fnd_nxt = MSG_ERR;
            default: w_fnd_nxt = w_val_nxt;
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag       <= '0;
            r_neg       <= 1'b0;
            r_state     <= ST_IDLE;
            r_timer     <= 24'd0;
            r_msg       <= 32'd0;
            r_op_pend   <= 1'b0;
            r_op_code   <= OP_NONE;
            r_op_valid  <= 1'b0;
            r_key_ready <= 1'b1;
            r_fnd       <= 32'd0;
            r_operand   <= 32'd0;
        end else begin
            r_mag       <= w_mag_nxt;
            r_neg       <= w_neg_nxt;
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_msg       <= w_msg_nxt;
            r_op_pend   <= w_pend_nxt;
            r_op_code   <= w_op_code_nxt;
            r_op_valid  <= w_op_valid_nxt;
            r_key_ready <= (w_state_nxt != ST_DIV) ? 1'b1 : 1'b0;
            r_fnd       <= w_fnd_nxt;
            r_operand   <= w_val_nxt;
        end
    end

    seq_div10 #(.MAG_W(MAG_W)) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_dividend (w_mag_b),
        .o_busy     (w_div_busy),
        .o_done     (w_div_done),
        .o_quot     (w_div_quot)
    );

    assign o_key_ready  = r_key_ready;
    assign o_fnd_serial = r_fnd;
    assign o_operand    = r_operand;
    assign o_op_valid   = r_op_valid;
    assign o_op_code    = r_op_code;

endmodule

// File: doc/num_entry.md
Name: num_entry

Overview:
- Keypad number-entry stage that sits directly upstream of the seven-segment driver.
- Accepts decoded key events and builds a signed decimal operand of up to 5 digits.
- Drives the driver's 32-bit display word (fnd_serial): two's-complement value or fixed message code.
- Emits one operator event per operator key for the downstream calculator core.

Parameters:
- MAG_W, 17, magnitude register width; must hold MAX_MAG.
- MAX_MAG, 99999, largest enterable magnitude (5 digits; segment 5 reserved for sign).
- MSG_CYCLES, 24'd12_000_000, cycles an operator/HAPPY message stays displayed.
- ERR_CYCLES, 24'd12_000_000, cycles the Error message stays displayed.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- key_valid  in  1  key event strobe; a key is accepted when key_valid && key_ready
- key_code  in  5  0-9 digit, 10 sign, 11 backspace, 12 clear, 13 plus, 14 minus, 15 mul, 16 div, 17 mod; 18-31 ignored
- key_ready  out  1  high when a key can be accepted
- fnd_serial  out  32  display word to the segment driver
- operand  out  32  current signed entry value, two's complement
- op_valid  out  1  one-cycle pulse on operator key acceptance
- op_code  out  3  1 plus, 2 minus, 3 mul, 4 div, 5 mod; held until next op_valid

Behaviour:
- Reset (async): mag=0, neg=0, state=IDLE, key_ready=1, fnd_serial=0, operand=0, op_valid=0, op_code=0, timer=0.
- States: IDLE, DIV, MSG, ERR. Display word: IDLE/DIV show value = neg ? -mag : mag (sign-extended to 32 bits); MSG shows the latched message code; ERR shows 32'h00EE_0000.
- Message codes: plus 32'h0010_0000, minus 32'h0020_0000, mul 32'h0030_0000, div 32'h0040_0000, mod 32'h0050_0000, HAPPY 32'h00A0_0000.
- operand always equals the signed value, including in MSG and ERR.
- All register outputs update on the clock edge after acceptance (1-cycle latency), except backspace.
- Digit d: if mag*10+d <= MAX_MAG, then mag <= mag*10+d. Otherwise mag is unchanged and state goes to ERR with timer=ERR_CYCLES.
- Sign key: toggles neg only when mag != 0. Ignored when mag == 0, so negative zero never exists.
- Backspace: state goes to DIV and key_ready=0 for exactly MAG_W cycles while the restoring divider computes mag/10 (remainder discarded). On the final DIV cycle mag takes the quotient; if the quotient is 0, neg is also cleared; state returns to IDLE. The new value is visible MAG_W+1 edges after acceptance.
- Clear: mag=0, neg=0, state=IDLE.
- Operator key:
  - op_valid=1 for one cycle; op_code is set; operand on that same cycle is the pre-clear value.
  - Next cycle: mag=0, neg=0, state=MSG, timer=MSG_CYCLES.
- Codes 18-31: accepted and ignored; no state change.
- MSG/ERR: timer decrements each cycle; at 1 it returns to IDLE. A key accepted in MSG/ERR aborts the message and is processed as if in IDLE in the same cycle.
- key_ready=0 only in DIV; key_valid during DIV is dropped, not queued.
- Reset asserted mid-DIV: divider is abandoned and all registers take reset values.

Optional Feature:
- Macro NUM_ENTRY_HAPPY_EN.
- Defined: the clear key pressed while mag==0 and state==IDLE enters MSG with code 32'h00A0_0000 for MSG_CYCLES.
- Undefined: clear is always a plain clear; the HAPPY code is never produced.

Decomposition:
- Package num_entry_pkg: key code constants, op code constants, message display-code constants, MAX_MAG default.
- Sub-module seq_div10: start/busy/done restoring divider by 10, MAG_W iterations, quotient output; instanced once.

Test Plan:
- Keys 1,2,3 → fnd_serial=123 and operand=123; then sign → fnd_serial=32'hFFFF_FF85 (-123).
- Keys 9,9,9,9,9,7 → 6th digit rejected; fnd_serial=32'h00EE_0000 for ERR_CYCLES, then 99999.
- Value -5, then backspace → key_ready low exactly MAG_W cycles; then mag=0, neg=0, fnd_serial=0; key_valid pulsed during DIV has no effect.
- Value 42, then key 15 → op_valid single pulse with op_code=3 and operand=42; fnd_serial=32'h0030_0000; digit 7 during MSG → fnd_serial=7 next cycle.
- Reset asserted mid-DIV and mid-MSG → all outputs at reset values asynchronously; key_ready=1 after release.
- NUM_ENTRY_HAPPY_EN defined, mag=0, clear → fnd_serial=32'h00A0_0000; macro undefined → stays 0.
